regfile_port_ctrl: RTL and testbench
====================================

# regfile_port_ctrl

Sequencing and sharing controller for the 32×32 register file of the single-cycle RISC-V core. After reset it clears every register to zero, so no location ever reads as X. It then passes the core's writeback and read port 1 straight through to the register file. A debug requester can steal the ports for one stalled core cycle to read or write any register.

## Interface
- NREG, 32, number of registers to clear; equals 2**AW
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous request to re-run the clear sequence; sampled only in RUN
- core_werf  in  1  core writeback enable
- core_wa  in  AW  core write address
- core_wd  in  DW  core write data
- core_ra1  in  AW  core read address, port 1
- core_stall  out  1  core must hold its PC and suppress side effects this cycle
- init_busy  out  1  clear sequence in progress
- rf_werf  out  1  register file write enable
- rf_wa  out  AW  register file write address
- rf_wd  out  DW  register file write data
- rf_ra1  out  AW  register file read address, port 1 (port 2 is wired directly from the core)
- rf_rd1  in  DW  register file read data, port 1 (combinational read)
- dbg_req  in  1  debug access request; level, held until ack
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  AW  debug register address
- dbg_wdata  in  DW  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DW  registered read data, valid while dbg_ack = 1

## Operation
- States: INIT, RUN, DBG, ACK. The state register and the index counter idx (AW bits) are the only sequential state, plus dbg_rdata.
- Reset (rst_n = 0):
  - state = INIT, idx = 0, dbg_rdata = 0, dbg_ack = 0.
  - rf_werf is forced to 0 while rst_n = 0.
  - core_stall = 1, init_busy = 1.
- INIT:
  - rf_werf = 1, rf_wa = idx, rf_wd = 0, rf_ra1 = core_ra1, core_stall = 1, init_busy = 1.
  - idx increments each cycle.
  - When idx = NREG-1: idx → 0 and the next state is RUN.
  - dbg_req is ignored in INIT.
- RUN:
  - rf_werf/rf_wa/rf_wd = core_werf/core_wa/core_wd; rf_ra1 = core_ra1; core_stall = 0.
  - If clr = 1, the next state is INIT. clr has priority over dbg_req; the pending debug request stays pending and is served after INIT.
  - Otherwise, if dbg_req = 1, the next state is DBG. The core's write in this cycle still completes.
- DBG (exactly one cycle):
  - core_stall = 1 and the core_* inputs are ignored.
  - rf_werf = dbg_we, rf_wa = dbg_addr, rf_wd = dbg_wdata, rf_ra1 = dbg_addr.
  - dbg_rdata ← rf_rd1 at the clock edge leaving DBG. This is the pre-write value when dbg_we = 1.
  - The next state is ACK.
- ACK:
  - Behaves as RUN for the core (pass-through, core_stall = 0).
  - dbg_ack = 1; dbg_rdata holds its value until the next DBG.
  - The next state is RUN unconditionally; clr and dbg_req are not sampled in ACK.
  - The requester must drop dbg_req in the cycle it sees dbg_ack.
- Address 0: writes are forwarded unchanged. The register file itself enforces x0 = 0; the controller does not special-case it.
- No arithmetic beyond the idx increment. idx wraps from NREG-1 to 0 exactly at the INIT exit.

## Timing
- Clear latency: INIT occupies NREG cycles (32), starting at the first rising edge with rst_n = 1.
  - Edges 0..31 write registers 0..31.
  - The first RUN cycle is the 33rd cycle; init_busy falls at the same time.
- Debug access timing:
  - Request seen in RUN cycle T.
  - DBG (stall) in cycle T+1.
  - dbg_ack is high in cycle T+2.
  - Total cost: one core stall cycle.
- Back-to-back debug: the earliest re-grant is DBG in T+4, since the request is re-sampled in the RUN cycle T+3.
- Reset mid-operation: asynchronous return to INIT with idx = 0.
  - No dbg_ack is issued for an aborted DBG or ACK.
  - The clear restarts from register 0.
- clr during INIT is ignored; the sequence does not restart.

## Test plan
- Release rst_n → 32 consecutive cycles of rf_werf = 1 with rf_wa = 0..31 and rf_wd = 0, init_busy = 1; then init_busy = 0. Reading registers 7 and 18 returns 0x00000000, not X.
- RUN, core writes wa = 10, wd = 56 → pass-through to rf_*; next cycle, ra2 = 10 gives rd2 = 0x38. A write to wa = 0 with wd = 66 leaves x0 = 0.
- dbg_req read, dbg_addr = 10 → core_stall high for exactly 1 cycle; next cycle dbg_ack = 1 with dbg_rdata = 0x00000038.
- dbg write of 12 = 69 while the core drives core_werf = 1, wa = 12, wd = 1 in the DBG cycle → the core write is suppressed and register 12 reads 0x45. dbg_rdata = 0 (the pre-write value).
- clr and dbg_req asserted in the same RUN cycle → INIT for 32 cycles with no ack. Then DBG, then ack; the debug read returns 0.
- rst_n pulsed low when idx = 7 → rf_werf drops to 0 immediately; after release, the clear restarts at rf_wa = 0 and runs a full 32 cycles.

Source files
------------

// File: rtl/regfile_port_ctrl.sv
// Port sequencer for the 32x32 core register file: clears every register after
// reset or clr, then passes core traffic through and lends the write port and
// read port 1 to a debug requester for one stalled core cycle.
module regfile_port_ctrl #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          core_werf,
    input  logic [AW-1:0] core_wa,
    input  logic [DW-1:0] core_wd,
    input  logic [AW-1:0] core_ra1,
    output logic          core_stall,
    output logic          init_busy,
    output logic          rf_werf,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic [AW-1:0] rf_ra1,
    input  logic [DW-1:0] rf_rd1,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata
);

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DBG  = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    localparam logic [AW-1:0] IDX_LAST = AW'(NREG - 1);

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_next;
    logic [DW-1:0] rdata_next;
    logic          wr_en;

    // State, clear index and captured debug read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            idx       <= '0;
            dbg_rdata <= '0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            dbg_rdata <= rdata_next;
        end
    end

    // Next-state and port steering; core pass-through is the default.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        rdata_next = dbg_rdata;
        wr_en      = core_werf;
        rf_wa      = core_wa;
        rf_wd      = core_wd;
        rf_ra1     = core_ra1;
        core_stall = 1'b0;
        init_busy  = 1'b0;
        dbg_ack    = 1'b0;

        case (state)
            S_INIT: begin
                wr_en      = 1'b1;
                rf_wa      = idx;
                rf_wd      = '0;
                core_stall = 1'b1;
                init_busy  = 1'b1;
                if (idx == IDX_LAST) begin
                    idx_next   = '0;
                    state_next = S_RUN;
                end else begin
                    idx_next = idx + AW'(1);
                end
            end
            S_RUN: begin
                // clr wins; a concurrent debug request stays pending across the clear
                if (clr) begin
                    state_next = S_INIT;
                end else if (dbg_req) begin
                    state_next = S_DBG;
                end
            end
            S_DBG: begin
                core_stall = 1'b1;
                wr_en      = dbg_we;
                rf_wa      = dbg_addr;
                rf_wd      = dbg_wdata;
                rf_ra1     = dbg_addr;
                // read is combinational, so this is the pre-write value on a debug write
                rdata_next = rf_rd1;
                state_next = S_ACK;
            end
            S_ACK: begin
                dbg_ack    = 1'b1;
                state_next = S_RUN;
            end
            default: begin
                state_next = S_INIT;
                idx_next   = '0;
            end
        endcase
    end

    // No register-file write may leak out while reset is asserted.
    assign rf_werf = rst_n & wr_en;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a small behavioural register file.
module tb_regfile_port_ctrl;

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          core_werf;
    logic [AW-1:0] core_wa;
    logic [DW-1:0] core_wd;
    logic [AW-1:0] core_ra1;
    logic          core_stall;
    logic          init_busy;
    logic          rf_werf;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic [AW-1:0] rf_ra1;
    logic [DW-1:0] rf_rd1;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;

    logic [AW-1:0] ra2;
    logic [DW-1:0] rd2;
    logic [DW-1:0] regs [NREG];

    int checks = 0;
    int errors = 0;

    regfile_port_ctrl #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .core_werf  (core_werf),
        .core_wa    (core_wa),
        .core_wd    (core_wd),
        .core_ra1   (core_ra1),
        .core_stall (core_stall),
        .init_busy  (init_busy),
        .rf_werf    (rf_werf),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .rf_ra1     (rf_ra1),
        .rf_rd1     (rf_rd1),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata)
    );

    always #5 clk = ~clk;

    // Register file model: poisoned while in reset, x0 hardwired to zero.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) regs[r] <= 32'hDEAD_BEEF;
        end else if (rf_werf && rf_wa != '0) begin
            regs[rf_wa] <= rf_wd;
        end
    end

    assign rf_rd1 = (rf_ra1 == '0) ? '0 : regs[rf_ra1];
    assign rd2    = (ra2 == '0) ? '0 : regs[ra2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0;
        core_werf = 1'b0; core_wa = '0; core_wd = '0; core_ra1 = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        ra2 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_werf", 32'(rf_werf), 32'd0);
        check("rst_stall", 32'(core_stall), 32'd1);
        check("rst_busy", 32'(init_busy), 32'd1);
        check("rst_ack", 32'(dbg_ack), 32'd0);
        check("rst_rdata", dbg_rdata, 32'd0);

        // Clear sequence after release
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            check("init_werf", 32'(rf_werf), 32'd1);
            check("init_wa", 32'(rf_wa), 32'(i));
            check("init_wd", rf_wd, 32'd0);
            check("init_busy", 32'(init_busy), 32'd1);
            step();
        end
        check("run_busy", 32'(init_busy), 32'd0);
        check("run_stall", 32'(core_stall), 32'd0);
        core_ra1 = 5'd7;
        #1 check("rd_r7", rf_rd1, 32'd0);
        core_ra1 = 5'd18;
        #1 check("rd_r18", rf_rd1, 32'd0);
        check("ra1_pass", 32'(rf_ra1), 32'd18);

        // Core write pass-through
        core_werf = 1'b1; core_wa = 5'd10; core_wd = 32'd56;
        #1;
        check("wr_werf", 32'(rf_werf), 32'd1);
        check("wr_wa", 32'(rf_wa), 32'd10);
        check("wr_wd", rf_wd, 32'd56);
        step();
        ra2 = 5'd10;
        core_wa = 5'd0; core_wd = 32'd66;
        #1;
        check("rd2_r10", rd2, 32'h38);
        check("wr0_wa", 32'(rf_wa), 32'd0);
        check("wr0_wd", rf_wd, 32'd66);
        step();
        core_werf = 1'b0;
        ra2 = 5'd0;
        #1 check("rd2_x0", rd2, 32'd0);

        // Debug read of r10
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd10;
        #1 check("dreq_stall", 32'(core_stall), 32'd0);
        step();
        check("dbg_stall", 32'(core_stall), 32'd1);
        check("dbg_ra1", 32'(rf_ra1), 32'd10);
        check("dbg_werf", 32'(rf_werf), 32'd0);
        check("dbg_noack", 32'(dbg_ack), 32'd0);
        step();
        check("ack_rd", 32'(dbg_ack), 32'd1);
        check("ack_rdata", dbg_rdata, 32'h38);
        check("ack_stall", 32'(core_stall), 32'd0);
        dbg_req = 1'b0;
        step();
        check("post_ack", 32'(dbg_ack), 32'd0);
        check("post_stall", 32'(core_stall), 32'd0);
        check("hold_rdata", dbg_rdata, 32'h38);

        // Debug write r12 = 69 while the core also tries to write r12
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd12; dbg_wdata = 32'd69;
        step();
        core_werf = 1'b1; core_wa = 5'd12; core_wd = 32'd1;
        #1;
        check("dw_stall", 32'(core_stall), 32'd1);
        check("dw_werf", 32'(rf_werf), 32'd1);
        check("dw_wa", 32'(rf_wa), 32'd12);
        check("dw_wd", rf_wd, 32'd69);
        step();
        core_werf = 1'b0;
        dbg_req = 1'b0; dbg_we = 1'b0;
        ra2 = 5'd12;
        #1;
        check("dw_ack", 32'(dbg_ack), 32'd1);
        check("dw_prewrite", dbg_rdata, 32'd0);
        check("dw_r12", rd2, 32'h45);
        step();

        // clr and dbg_req together: clear first, then serve the read of r12
        clr = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd12;
        step();
        clr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("clr_busy", 32'(init_busy), 32'd1);
            check("clr_wa", 32'(rf_wa), 32'(i));
            check("clr_noack", 32'(dbg_ack), 32'd0);
            step();
        end
        check("clr_run", 32'(core_stall), 32'd0);
        check("clr_r12", rd2, 32'd0);
        step();
        check("clr_dbg", 32'(core_stall), 32'd1);
        step();
        check("clr_ack", 32'(dbg_ack), 32'd1);
        check("clr_rdata", dbg_rdata, 32'd0);
        dbg_req = 1'b0;
        step();

        // Reset pulse in the middle of a clear
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (7) step();
        check("mid_wa7", 32'(rf_wa), 32'd7);
        rst_n = 1'b0;
        #1;
        check("mid_werf", 32'(rf_werf), 32'd0);
        check("mid_busy", 32'(init_busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            // clr during INIT must not restart the sequence
            clr = (i == 3);
            #1;
            check("re_wa", 32'(rf_wa), 32'(i));
            check("re_werf", 32'(rf_werf), 32'd1);
            step();
        end
        clr = 1'b0;
        #1;
        check("re_done", 32'(init_busy), 32'd0);
        check("re_noack", 32'(dbg_ack), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
